// File: rtl/axi_rd_pkg.sv
// Shared types and AXI encodings for the burst read master and its beat buffer.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // EXOKAY is never expected from a plain read, so anything but OKAY is flagged.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_rd_beat_fifo.sv
// Synchronous beat buffer; push visible at the output the cycle after the write edge.
// Backpressure: o_full blocks pushes unless a pop happens in the same cycle.
module axi_rd_beat_fifo
  import axi_rd_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_full,
  input  logic             i_pop_rdy,
  output logic             o_pop_vld,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = i_pop_rdy && !o_empty;
  assign w_push    = i_push_vld && (!o_full || w_pop);
  assign o_pop_vld = !o_empty;
  assign o_pop_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_burst_read_master.sv
// Single-outstanding AXI4 INCR read master; accept->ARVALID 1 cycle, R beat->out_valid 1 cycle.
// Backpressure: RREADY drops while the beat buffer is full; hold_in blocks new requests only.
module axi_burst_read_master
  import axi_rd_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [LEN_W-1:0]  ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              hold_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err,
  output logic              busy
);

  localparam int CNT_W = LEN_W + 1;
  localparam int FW    = DATA_W + 2;

  state_t              r_state;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [ID_W-1:0]     r_arid;
  logic [LEN_W-1:0]    r_arlen;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_req_en;

  logic                w_req_fire;
  logic                w_r_fire;
  logic                w_exp_last;
  logic                w_overrun;
  logic                w_beat_err;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [FW-1:0]       w_push_dat;
  logic [FW-1:0]       w_pop_dat;

  assign ARID    = r_arid;
  assign ARADDR  = r_araddr;
  assign ARLEN   = r_arlen;
  assign ARSIZE  = SIZE_4B;
  assign ARBURST = BURST_INCR;
  assign ARVALID = r_arvalid;

  // r_req_en keeps req_ready low while reset is asserted.
  assign req_ready  = r_req_en && (r_state == ST_IDLE) && !hold_in;
  assign w_req_fire = req_valid && req_ready;
  assign RREADY     = (r_state == ST_DATA) && !w_fifo_full;
  assign w_r_fire   = RVALID && RREADY;

  // A beat is suspect if its RLAST disagrees with the requested length or it overruns it.
  assign w_exp_last = (r_beat_cnt == {1'b0, r_arlen});
  assign w_overrun  = (r_beat_cnt > {1'b0, r_arlen});
  assign w_beat_err = resp_is_err(RRESP) || (RID != r_arid) ||
                      (RLAST != w_exp_last) || w_overrun;
  assign w_push_dat = {RDATA, RLAST, w_beat_err};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_arvalid  <= 1'b0;
      r_araddr   <= '0;
      r_arid     <= '0;
      r_arlen    <= '0;
      r_beat_cnt <= '0;
      r_req_en   <= 1'b0;
    end else begin
      r_req_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_araddr   <= req_addr;
            r_arid     <= req_id;
            r_arlen    <= req_len;
            r_beat_cnt <= '0;
            r_arvalid  <= 1'b1;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_fire) begin
            if (r_beat_cnt != {CNT_W{1'b1}}) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (RLAST) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  axi_rd_beat_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_beat_fifo (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .i_push_vld (w_r_fire),
    .i_push_dat (w_push_dat),
    .o_full     (w_fifo_full),
    .i_pop_rdy  (out_ready),
    .o_pop_vld  (out_valid),
    .o_pop_dat  (w_pop_dat),
    .o_empty    (w_fifo_empty)
  );

  assign out_data = w_pop_dat[FW-1:2];
  assign out_last = w_pop_dat[1];
  assign out_err  = w_pop_dat[0];
  assign busy     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Directed bench: IDLE/hold vectors and burst records applied from tables, plus a mid-burst reset.
module tb_axi_burst_read_master;

  logic        ACLK;
  logic        ARESETn;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_id;
  logic [3:0]  req_len;
  logic        hold_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_err;
  logic        busy;

  int n_cmp;
  int n_bad;
  int sent;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    int          rlast_at;
    int          ar_dly;
    bit          hold_mid;
    int          stall;
    int          resp_bad;
    int          rid_bad;
    logic [31:0] base;
    int          exp_beats;
    logic [15:0] exp_err;
  } vec_t;

  typedef struct {
    bit hold;
    bit valid;
    bit exp_rdy;
    bit exp_arv;
  } idle_t;

  vec_t  tbl [7];
  idle_t tbl_idle [4];

  axi_burst_read_master #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .FIFO_DEPTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_id(req_id),
    .req_len(req_len), .hold_in(hold_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_arid", ARID, 0);
    chk("rst_arlen", ARLEN, 0);
    chk("rst_arsize", ARSIZE, 3'b010);
    chk("rst_arburst", ARBURST, 2'b01);
    chk("rst_rready", RREADY, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic do_req(input vec_t v);
    bit ok;
    int cyc;
    @(posedge ACLK); #1;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_id    = v.id;
    req_len   = v.len;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
      if (cyc == 1) chk("pre_arvalid", ARVALID, 0);
      ok = req_ready;
      @(posedge ACLK); #1;
    end
    req_valid = 1'b0;
    chk("req_accept", ok, 1);
  endtask

  // Slave side: AR handshake after ar_dly cycles, then up to max_beats R beats.
  task automatic slave(input vec_t v, input int max_beats);
    bit done;
    bit hs;
    int n;
    int cyc;
    int nb;
    sent    = 0;
    ARREADY = (v.ar_dly == 0);
    done = 1'b0;
    n    = 0;
    cyc  = 0;
    while (!done && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      if (ARVALID) begin
        n++;
        if (n == 1) chk("ar_latency", cyc, 1);
        chk("araddr", ARADDR, v.addr);
        chk("arid", ARID, v.id);
        chk("arlen", ARLEN, v.len);
        if (ARREADY) done = 1'b1;
      end
      @(posedge ACLK); #1;
      if (done) begin
        ARREADY = 1'b0;
        hold_in = 1'b0;
      end else if (n > 0) begin
        if (n >= v.ar_dly) ARREADY = 1'b1;
        if (v.hold_mid) hold_in = 1'b1;
      end
    end
    chk("ar_done", done, 1);
    chk("ar_cycles", n, v.ar_dly + 1);
    chk("arsize", ARSIZE, 3'b010);
    chk("arburst", ARBURST, 2'b01);
    nb = v.rlast_at + 1;
    if (nb > max_beats) nb = max_beats;
    for (int k = 0; k < nb; k++) begin
      RVALID = 1'b1;
      RDATA  = v.base + k;
      RID    = (k == v.rid_bad) ? (v.id ^ 4'h2) : v.id;
      RRESP  = (k == v.resp_bad) ? 2'b10 : 2'b00;
      RLAST  = (k == v.rlast_at);
      hs  = 1'b0;
      cyc = 0;
      while (!hs && cyc < 300) begin
        @(negedge ACLK);
        cyc++;
        hs = RREADY;
        @(posedge ACLK); #1;
      end
      if (!hs) begin
        chk("r_handshake", hs, 1);
        break;
      end
      sent++;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
  endtask

  task automatic consumer(input vec_t v);
    int k;
    int cyc;
    out_ready = (v.stall == 0);
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge ACLK);
      @(negedge ACLK);
      chk("stall_rready", RREADY, 0);
      chk("stall_beats_in", sent, 4);
      chk("stall_out_valid", out_valid, 1);
      @(posedge ACLK); #1;
      out_ready = 1'b1;
    end
    k   = 0;
    cyc = 0;
    while (k < v.exp_beats && cyc < 400) begin
      @(negedge ACLK);
      cyc++;
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, v.base + k);
        chk("beat_last", out_last, (k == v.exp_beats - 1));
        chk("beat_err", out_err, v.exp_err[k]);
        k++;
      end
    end
    chk("beat_count", k, v.exp_beats);
    @(negedge ACLK);
    chk("busy_after_drain", busy, 0);
    chk("out_valid_after_drain", out_valid, 0);
  endtask

  task automatic run_burst(input vec_t v);
    do_req(v);
    fork
      slave(v, 64);
      consumer(v);
    join
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sent  = 0;

    //           addr           id    len   rl  dly hold stall resp rid  base           nb  err
    tbl[0] = '{32'h1000_0000, 4'd3, 4'd0,  0,  0, 1'b0,  0,  -1, -1, 32'hDEAD_BEEF,  1, 16'h0000};
    tbl[1] = '{32'h2000_0040, 4'd5, 4'd15, 15, 3, 1'b0,  0,  -1, -1, 32'hA000_0000, 16, 16'h0000};
    tbl[2] = '{32'h3000_0000, 4'd2, 4'd7,  7,  0, 1'b0, 12,  -1, -1, 32'hB000_0000,  8, 16'h0000};
    tbl[3] = '{32'h4000_0000, 4'd1, 4'd1,  1,  3, 1'b1,  0,  -1, -1, 32'hC000_0000,  2, 16'h0000};
    tbl[4] = '{32'h5000_0000, 4'd3, 4'd15, 15, 1, 1'b0,  0,   5,  7, 32'hD000_0000, 16, 16'h00A0};
    tbl[5] = '{32'h6000_0000, 4'd4, 4'd3,  1,  0, 1'b0,  0,  -1, -1, 32'hE000_0000,  2, 16'h0002};
    tbl[6] = '{32'h7000_0000, 4'd6, 4'd1,  2,  0, 1'b0,  0,  -1, -1, 32'hF000_0000,  3, 16'h0006};

    tbl_idle[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl_idle[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl_idle[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl_idle[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    ARESETn   = 1'b1;
    ARREADY   = 1'b0;
    RID       = '0;
    RDATA     = '0;
    RRESP     = '0;
    RLAST     = 1'b0;
    RVALID    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_id    = '0;
    req_len   = '0;
    hold_in   = 1'b0;
    out_ready = 1'b1;
    #3 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    foreach (tbl_idle[i]) begin
      @(posedge ACLK); #1;
      hold_in   = tbl_idle[i].hold;
      req_valid = tbl_idle[i].valid;
      req_addr  = 32'h0BAD_0000;
      @(negedge ACLK);
      chk("idle_req_ready", req_ready, tbl_idle[i].exp_rdy);
      chk("idle_arvalid", ARVALID, tbl_idle[i].exp_arv);
    end
    @(posedge ACLK); #1;
    req_valid = 1'b0;
    hold_in   = 1'b0;
    @(negedge ACLK);
    chk("idle_no_ar", ARVALID, 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_burst(tbl[i]);
    end

    // Reset after 8 of 16 beats, then a fresh request must complete normally.
    out_ready = 1'b1;
    do_req(tbl[1]);
    slave(tbl[1], 8);
    chk("mid_beats_sent", sent, 8);
    ARESETn = 1'b0;
    #1;
    check_reset();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    run_burst(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
